mcu_sample_rom: RTL and testbench
=================================

MCU_SAMPLE_ROM -- requirements
Module: mcu_sample_rom

Interface
REQ-001 SHALL have parameter SDR_BASE, default 25'h0000000: SDRAM byte base address of the sample ROM region.
REQ-002 SHALL have port CLK_32M  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sample_addr_wr  input  2  bit0 loads address[7:0], bit1 loads address[15:8] from sample_addr; one-cycle strobes.
REQ-005 SHALL have port sample_addr  input  16  address write data; only the byte lane(s) selected by sample_addr_wr are used.
REQ-006 SHALL have port sample_inc  input  1  one-cycle strobe: advance sample address by 1.
REQ-007 SHALL have port sample_rom_data  output  8  byte at the current sample address.
REQ-008 SHALL have port data_valid  output  1  high when sample_rom_data matches the current address.
REQ-009 SHALL have port sdr_addr  output  25  SDRAM byte address, word aligned (bit0 = 0).
REQ-010 SHALL have port sdr_req  output  1  toggle request; a request is issued by inverting sdr_req.
REQ-011 SHALL have port sdr_ack  input  1  toggle acknowledge; request complete when sdr_ack == sdr_req.
REQ-012 SHALL have port sdr_data  input  16  SDRAM word, valid in the cycle completion is detected.

Function
REQ-013 SHALL hold a 16-bit address register; sdr_addr = SDR_BASE + {addr[15:1],1'b0}; addr[0]=0 selects sdr_data[7:0], 1 selects [15:8].
REQ-014 SHALL hold a current-word buffer (tag = addr[15:1], 16-bit data, valid) and a next-word buffer of the same form.
REQ-015 SHALL use states IDLE, FETCH (request outstanding for current word), PREFETCH (request outstanding for next word).
REQ-016 SHALL in IDLE with current-word invalid, issue a request for the current tag and enter FETCH in the next cycle.
REQ-017 SHALL on completion in FETCH, write the current buffer if its tag still matches, else discard; then return to IDLE.
REQ-018 SHALL never cancel an outstanding request; an address change mid-request waits for completion, discards data, then re-requests.
REQ-019 SHALL on address write, apply the selected byte lanes and invalidate the current buffer unless the new tag equals the current tag.
REQ-020 SHALL on sample_inc, increment addr modulo 2^16 (0xFFFF -> 0x0000, wrap crosses to tag 0).
REQ-021 SHALL on sample_inc within the same word (addr[0] 0->1), keep the current buffer valid; data_valid stays high.
REQ-022 SHALL on sample_inc crossing a word, promote the next buffer to current in the same cycle if valid and tag-matching, else invalidate current.
REQ-023 SHALL give priority to sample_addr_wr over sample_inc in the same cycle; the increment is dropped.
REQ-024 SHALL drive sample_rom_data from the current buffer's selected byte, registered; hold the last value while data_valid is low.
REQ-025 SHALL register data_valid, asserting one cycle after the current buffer becomes valid for the current address.
REQ-026 SHALL guarantee hit latency (same word or prefetch hit) of 1 cycle from sample_inc to updated sample_rom_data.
REQ-027 SHALL guarantee miss latency of at most 2 cycles plus SDRAM acknowledge time.

Reset
REQ-028 SHALL on reset_n low set addr=0, both buffers invalid, sample_rom_data=8'h00, data_valid=0, sdr_req=0, state IDLE, asynchronously.
REQ-029 SHALL after reset_n release issue the first fetch (address 0) from IDLE without requiring an address write.
REQ-030 SHALL, if reset asserts with a request outstanding, resume from sdr_req=0 and ignore any acknowledge arriving while sdr_ack != sdr_req.

Configuration
REQ-031 SHALL support macro MCU_SAMPLE_PREFETCH_EN: when defined, IDLE with current valid and next invalid or mismatched requests tag+1 (mod 2^15) and enters PREFETCH; on completion next buffer is written if tag+1 still matches.
REQ-032 SHALL without MCU_SAMPLE_PREFETCH_EN omit the next buffer and PREFETCH state; every word crossing is a miss.

Verification
REQ-033 SHALL test: write 0x34 (wr=01) then 0x12 (wr=10), SDRAM returns 0xBBAA at SDR_BASE+0x1234 -> sdr_addr=SDR_BASE+0x1234, sample_rom_data=0xAA, data_valid=1.
REQ-034 SHALL test: at 0x1234 valid, pulse sample_inc -> next cycle data 0xBB, no new sdr_req toggle before prefetch.
REQ-035 SHALL test with prefetch: at 0x1235, next word 0xDDCC prefetched, sample_inc -> data 0xCC one cycle later, data_valid never drops.
REQ-036 SHALL test: address 0xFFFF, sample_inc -> addr 0x0000, fetch at SDR_BASE+0, data_valid low until completion.
REQ-037 SHALL test: address write during outstanding FETCH (ack delayed 20 cycles) -> old data discarded, second request for new address, correct byte shown.
REQ-038 SHALL test: sample_addr_wr=11 and sample_inc same cycle with 0x5678 -> addr 0x5678, not 0x5679.

Source files
------------

// File: rtl/mcu_sample_rom.sv
// mcu_sample_rom
//   Byte-wide sample ROM window onto SDRAM. A 16-bit sample address selects a
//   byte; the containing 16-bit word is fetched over a toggle req/ack port and
//   held in a current-word buffer. Optional next-word prefetch keeps
//   sequential playback free of stalls at word boundaries.
//
//   Build option: define MCU_SAMPLE_PREFETCH_EN to add the next-word buffer
//   and the PREFETCH state. Without it every word crossing is a miss.
//
// Ports
//   CLK_32M          system clock, rising edge
//   reset_n          asynchronous active-low reset
//   sample_addr_wr   [0] loads addr[7:0], [1] loads addr[15:8] (strobes)
//   sample_addr      address write data
//   sample_inc       strobe: addr <= addr + 1 (address write wins)
//   sample_rom_data  registered byte at the current address
//   data_valid       registered: sample_rom_data matches the current address
//   sdr_addr         SDRAM byte address of the outstanding/last word request
//   sdr_req          toggle request
//   sdr_ack          toggle acknowledge, done when sdr_ack == sdr_req
//   sdr_data         SDRAM word, sampled in the completion cycle
module mcu_sample_rom #(
   parameter logic [24:0] SDR_BASE = 25'h0000000
) (
   input  logic        CLK_32M,
   input  logic        reset_n,
   input  logic [1:0]  sample_addr_wr,
   input  logic [15:0] sample_addr,
   input  logic        sample_inc,
   output logic [7:0]  sample_rom_data,
   output logic        data_valid,
   output logic [24:0] sdr_addr,
   output logic        sdr_req,
   input  logic        sdr_ack,
   input  logic [15:0] sdr_data
);

`ifdef MCU_SAMPLE_PREFETCH_EN
   typedef enum logic [1:0] {IDLE, FETCH, PREFETCH} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH} state_t;
`endif

   state_t      state, state_n;
   logic [15:0] addr, addr_n, addr_inc;
   logic [14:0] tag_n;
   // The current buffer's tag is addr[15:1] by construction: any change of
   // that tag either promotes a matching next word or invalidates the buffer.
   logic [15:0] cur_data, cur_data_n;
   logic        cur_vld, cur_vld_n;
   logic [14:0] req_tag, req_tag_n;
   logic        req_n;
   logic        done;

`ifdef MCU_SAMPLE_PREFETCH_EN
   logic [14:0] nxt_tag, nxt_tag_n;
   logic [15:0] nxt_data, nxt_data_n;
   logic        nxt_vld, nxt_vld_n;
`endif

   // Handshake is quiescent when ack has caught up with req. Gating new
   // requests on this also swallows a stale ack that lands after a reset.
   assign done     = (sdr_ack == sdr_req);
   assign addr_inc = addr + 16'd1;
   assign sdr_addr = SDR_BASE + {9'd0, req_tag, 1'b0};

   always_comb begin
      addr_n     = addr;
      cur_data_n = cur_data;
      cur_vld_n  = cur_vld;
      req_n      = sdr_req;
      req_tag_n  = req_tag;
      state_n    = state;
`ifdef MCU_SAMPLE_PREFETCH_EN
      nxt_tag_n  = nxt_tag;
      nxt_data_n = nxt_data;
      nxt_vld_n  = nxt_vld;
`endif

      // Address update: write beats increment.
      if (|sample_addr_wr) begin
         if (sample_addr_wr[0]) addr_n[7:0]  = sample_addr[7:0];
         if (sample_addr_wr[1]) addr_n[15:8] = sample_addr[15:8];
         if (addr_n[15:1] != addr[15:1]) cur_vld_n = 1'b0;
      end else if (sample_inc) begin
         addr_n = addr_inc;
         if (!addr_inc[0]) begin
`ifdef MCU_SAMPLE_PREFETCH_EN
            if (nxt_vld && (nxt_tag == addr_inc[15:1])) begin
               cur_data_n = nxt_data;
               cur_vld_n  = 1'b1;
               nxt_vld_n  = 1'b0;
            end else begin
               cur_vld_n  = 1'b0;
            end
`else
            cur_vld_n = 1'b0;
`endif
         end
      end
      tag_n = addr_n[15:1];

      // Fetch engine. Decisions use the post-update address so a miss is
      // requested in the same cycle the address moves. Requests are never
      // cancelled; stale completions are dropped by the tag compare.
      case (state)
         IDLE: begin
            if (done) begin
               if (!cur_vld_n) begin
                  req_n     = ~sdr_req;
                  req_tag_n = tag_n;
                  state_n   = FETCH;
               end
`ifdef MCU_SAMPLE_PREFETCH_EN
               else if (!(nxt_vld_n && (nxt_tag_n == tag_n + 15'd1))) begin
                  req_n     = ~sdr_req;
                  req_tag_n = tag_n + 15'd1;
                  state_n   = PREFETCH;
               end
`endif
            end
         end
         FETCH: begin
            if (done) begin
               if (req_tag == tag_n) begin
                  cur_data_n = sdr_data;
                  cur_vld_n  = 1'b1;
               end
               state_n = IDLE;
            end
         end
`ifdef MCU_SAMPLE_PREFETCH_EN
         PREFETCH: begin
            if (done) begin
               if (req_tag == tag_n + 15'd1) begin
                  nxt_tag_n  = req_tag;
                  nxt_data_n = sdr_data;
                  nxt_vld_n  = 1'b1;
               end
               state_n = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         addr     <= 16'h0000;
         cur_data <= 16'h0000;
         cur_vld  <= 1'b0;
         req_tag  <= 15'h0000;
         sdr_req  <= 1'b0;
`ifdef MCU_SAMPLE_PREFETCH_EN
         nxt_tag  <= 15'h0000;
         nxt_data <= 16'h0000;
         nxt_vld  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         addr     <= addr_n;
         cur_data <= cur_data_n;
         cur_vld  <= cur_vld_n;
         req_tag  <= req_tag_n;
         sdr_req  <= req_n;
`ifdef MCU_SAMPLE_PREFETCH_EN
         nxt_tag  <= nxt_tag_n;
         nxt_data <= nxt_data_n;
         nxt_vld  <= nxt_vld_n;
`endif
      end
   end

   // Output stage follows the buffer by one cycle; the byte holds while the
   // buffer is invalid.
   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         sample_rom_data <= 8'h00;
         data_valid      <= 1'b0;
      end else begin
         data_valid <= cur_vld;
         if (cur_vld) sample_rom_data <= addr[0] ? cur_data[15:8] : cur_data[7:0];
      end
   end

endmodule

// File: tb/tb_mcu_sample_rom.sv
module tb_mcu_sample_rom;
   localparam logic [24:0] BASE = 25'h0100000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  wr = 2'b00;
   logic [15:0] wdata = 16'h0000;
   logic        inc = 1'b0;
   logic [7:0]  rdata;
   logic        dvalid;
   logic [24:0] sdr_addr;
   logic        sdr_req;
   logic        sdr_ack = 1'b0;
   logic [15:0] sdr_data = 16'h0000;

   int checks = 0;
   int failures = 0;
   int ack_delay = 3;
   logic [7:0]  sb[$];
   logic [24:0] req_addrs[$];

   mcu_sample_rom #(.SDR_BASE(BASE)) dut (
      .CLK_32M(clk), .reset_n(rst_n), .sample_addr_wr(wr), .sample_addr(wdata),
      .sample_inc(inc), .sample_rom_data(rdata), .data_valid(dvalid),
      .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_data(sdr_data));

   always #5 clk = ~clk;

   // SDRAM contents as seen from the sample ROM base.
   function automatic logic [15:0] mem_word(input logic [24:0] off);
      logic [7:0] b;
      if (off == 25'h1234) return 16'hBBAA;
      if (off == 25'h1236) return 16'hDDCC;
      b = off[8:1] ^ off[16:9];
      return {b ^ 8'h3C, b};
   endfunction

   function automatic logic [7:0] exp_byte(input logic [15:0] a);
      logic [15:0] w;
      w = mem_word({9'd0, a[15:1], 1'b0});
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   // Toggle-handshake SDRAM model with programmable acknowledge delay.
   logic busy = 1'b0;
   int   cnt = 0;
   always @(posedge clk) begin
      if (busy) begin
         if (cnt <= 1) begin
            sdr_data <= mem_word(sdr_addr - BASE);
            sdr_ack  <= sdr_req;
            busy     <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end else if (sdr_req != sdr_ack) begin
         busy <= 1'b1;
         cnt  <= ack_delay;
         req_addrs.push_back(sdr_addr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] w, input logic [15:0] d, input logic i);
      @(negedge clk);
      wr = w; wdata = d; inc = i;
      @(negedge clk);
      wr = 2'b00; inc = 1'b0;
   endtask

   task automatic settle();
      repeat (40) @(negedge clk);
   endtask

   // Poll data_valid at negedges, then score the byte against the queue.
   task automatic wait_pop(input string name);
      bit ok;
      logic [7:0] e;
      ok = 0;
      for (int i = 0; i < 120; i++) begin
         if (dvalid) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL %s timeout actual=data_valid_low expected=data_valid_high", name);
      end else if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s scoreboard_empty actual=%0h expected=none", name, rdata);
      end else begin
         e = sb.pop_front();
         check(name, {24'd0, rdata}, {24'd0, e});
      end
   endtask

   task automatic check_req(input string name, input int idx, input logic [24:0] exp);
      if (req_addrs.size() > idx) check(name, {7'd0, req_addrs[idx]}, {7'd0, exp});
      else begin
         checks++; failures++;
         $display("FAIL %s no_request actual=none expected=%0h", name, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  wr;
      logic [15:0] wdata;
      logic [15:0] exp_addr;
      int          chk;   // 1: first new request address, 2: no new request
   } vec_t;
   vec_t vecs[6];

   initial begin
      int mark;
      vecs[0] = '{2'b01, 16'hEE34, 16'h0034, 1};
      vecs[1] = '{2'b10, 16'h12EE, 16'h1234, 1};
      vecs[2] = '{2'b11, 16'h0ABC, 16'h0ABC, 1};
      vecs[3] = '{2'b10, 16'h0B55, 16'h0BBC, 1};
      vecs[4] = '{2'b01, 16'h7701, 16'h0B01, 1};
      vecs[5] = '{2'b11, 16'h0B00, 16'h0B00, 2};

      // Reset state, before any clock edge and after a few edges in reset.
      #1;
      check("reset_valid_async", {31'd0, dvalid}, 32'd0);
      check("reset_data_async", {24'd0, rdata}, 32'd0);
      repeat (3) @(negedge clk);
      check("reset_req", {31'd0, sdr_req}, 32'd0);
      check("reset_valid", {31'd0, dvalid}, 32'd0);

      // First fetch of address 0 without any address write.
      sb.push_back(exp_byte(16'h0000));
      rst_n = 1'b1;
      wait_pop("boot_fetch_data");
      check_req("boot_fetch_addr", 0, BASE);

      // Address writes, byte lanes and same-tag rewrite.
      foreach (vecs[k]) begin
         settle();
         mark = req_addrs.size();
         sb.push_back(exp_byte(vecs[k].exp_addr));
         drive(vecs[k].wr, vecs[k].wdata, 1'b0);
         @(negedge clk);
         wait_pop($sformatf("vec%0d_data", k));
         if (vecs[k].chk == 1)
            check_req($sformatf("vec%0d_req", k), mark, BASE + {9'd0, vecs[k].exp_addr[15:1], 1'b0});
         else
            check($sformatf("vec%0d_noreq", k), req_addrs.size(), mark);
      end

      // 0x1234 -> 0x1235: same-word hit, one cycle, no new request.
      settle();
      sb.push_back(exp_byte(16'h1234));
      drive(2'b11, 16'h1234, 1'b0);
      @(negedge clk);
      wait_pop("at1234_data");
      check("at1234_aa", {24'd0, rdata}, 32'hAA);
      settle();
      mark = req_addrs.size();
      drive(2'b00, 16'h0000, 1'b1);
      @(negedge clk);
      check("inc_same_word_valid", {31'd0, dvalid}, 32'd1);
      check("inc_same_word_data", {24'd0, rdata}, 32'hBB);
      check("inc_same_word_noreq", req_addrs.size(), mark);

      // 0x1235 -> 0x1236: word crossing.
      sb.push_back(8'hCC);
      drive(2'b00, 16'h0000, 1'b1);
      check("cross_valid_e0", {31'd0, dvalid}, 32'd1);
      @(negedge clk);
`ifdef MCU_SAMPLE_PREFETCH_EN
      check("cross_hit_valid", {31'd0, dvalid}, 32'd1);
      wait_pop("cross_hit_data");
`else
      check("cross_miss_valid_low", {31'd0, dvalid}, 32'd0);
      wait_pop("cross_miss_data");
`endif

      // 0xFFFF -> 0x0000 wrap.
      settle();
      sb.push_back(exp_byte(16'hFFFF));
      drive(2'b11, 16'hFFFF, 1'b0);
      @(negedge clk);
      wait_pop("at_ffff_data");
      settle();
      mark = req_addrs.size();
      sb.push_back(exp_byte(16'h0000));
      drive(2'b00, 16'h0000, 1'b1);
      @(negedge clk);
`ifdef MCU_SAMPLE_PREFETCH_EN
      check("wrap_prefetch_valid", {31'd0, dvalid}, 32'd1);
      wait_pop("wrap_data");
`else
      check("wrap_valid_low", {31'd0, dvalid}, 32'd0);
      wait_pop("wrap_data");
      check_req("wrap_fetch_addr", mark, BASE);
`endif

      // Address change while a slow fetch is outstanding.
      settle();
      ack_delay = 20;
      mark = req_addrs.size();
      drive(2'b11, 16'h0200, 1'b0);
      repeat (5) @(negedge clk);
      sb.push_back(exp_byte(16'h0300));
      drive(2'b11, 16'h0300, 1'b0);
      @(negedge clk);
      check("midreq_valid_low", {31'd0, dvalid}, 32'd0);
      wait_pop("midreq_data");
      check_req("midreq_first", mark, BASE + 25'h0200);
      check_req("midreq_second", mark + 1, BASE + 25'h0300);
      ack_delay = 3;

      // Write and increment in the same cycle: the increment is dropped.
      settle();
      sb.push_back(exp_byte(16'h5678));
      drive(2'b11, 16'h5678, 1'b1);
      @(negedge clk);
      wait_pop("wr_inc_data");
      sb.push_back(exp_byte(16'h5679));
      drive(2'b00, 16'h0000, 1'b1);
      @(negedge clk);
      check("wr_inc_then_inc_valid", {31'd0, dvalid}, 32'd1);
      wait_pop("wr_inc_then_inc_data");

      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
